// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared SPI types and constants. Used by the peripheral and
//               by the SPI master, which uses the same mode type.
//               Provides the {cpol, cpha} mode struct, the peripheral state
//               enum, the frame length and the four standard mode encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int SPI_BITS = 8;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        XFER = 2'd2
    } spi_state_t;

    localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
    localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
    localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
    localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_input_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_input_sync
// Description : Brings the asynchronous SPI pins into the i_clk domain.
//               Each pin passes through SYNC_STAGES flip-flops and then one
//               history flip-flop. The edge strobes are registered, so the
//               latency from a pin change to its strobe is SYNC_STAGES+1
//               cycles. o_mosi is taken from the history stage so that it
//               is aligned with the strobes.
// Ports       : i_clk, i_rst          - clock, synchronous active-high reset
//               i_sclk/i_cs_n/i_mosi  - asynchronous SPI pins
//               o_mosi                - synchronized MOSI level
//               o_sclk_rise/_fall     - registered SCLK edge strobes
//               o_cs_fall/_rise       - registered chip-select edge strobes
// Revision    : 1.0 - initial release
// ============================================================================
module spi_input_sync #(
    parameter int SYNC_STAGES = 2   // must be >= 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_fall,
    output logic o_cs_rise
);

    // Bit order in every stage: [2] sclk, [1] cs_n, [0] mosi.
    // The reset value is the idle bus: clock low, deselected, MOSI high.
    localparam logic [2:0] c_PIN_RST = 3'b011;

    logic [2:0]                  w_pins;
    logic [2:0]                  w_last;
    logic [SYNC_STAGES-1:0][2:0] r_sync_q;
    logic [2:0]                  r_hist_q;
    logic                        r_sclk_rise_q;
    logic                        r_sclk_fall_q;
    logic                        r_cs_fall_q;
    logic                        r_cs_rise_q;

    assign w_pins = {i_sclk, i_cs_n, i_mosi};
    assign w_last = r_sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync_q      <= {SYNC_STAGES{c_PIN_RST}};
            r_hist_q      <= c_PIN_RST;
            r_sclk_rise_q <= 1'b0;
            r_sclk_fall_q <= 1'b0;
            r_cs_fall_q   <= 1'b0;
            r_cs_rise_q   <= 1'b0;
        end else begin
            r_sync_q      <= {r_sync_q[SYNC_STAGES-2:0], w_pins};
            r_hist_q      <= w_last;
            r_sclk_rise_q <=  w_last[2] & ~r_hist_q[2];
            r_sclk_fall_q <= ~w_last[2] &  r_hist_q[2];
            r_cs_fall_q   <= ~w_last[1] &  r_hist_q[1];
            r_cs_rise_q   <=  w_last[1] & ~r_hist_q[1];
        end
    end

    assign o_mosi      = r_hist_q[0];
    assign o_sclk_rise = r_sclk_rise_q;
    assign o_sclk_fall = r_sclk_fall_q;
    assign o_cs_fall   = r_cs_fall_q;
    assign o_cs_rise   = r_cs_rise_q;

endmodule : spi_input_sync
`default_nettype wire

// File: rtl/spi_peripheral.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : spi_peripheral
// Description : SPI responder. Oversamples SCLK/CS_N/MOSI in the i_clk
//               domain and exchanges 8-bit MSB-first frames in all four
//               SPI modes.
// Ports       : i_clk, i_rst                  - clock, sync active-high reset
//               i_sclk, i_cs_n, i_mosi, o_miso - SPI pins
//               i_tx_valid/i_tx_bits/o_tx_ready - byte to transmit (Decoupled)
//               o_rx_valid/o_rx_bits/i_rx_ready - received byte (Decoupled)
//               i_mode_valid/i_mode_bits/o_mode_ready - {cpol,cpha} update
//               o_spi_mode  - current mode
//               o_busy      - transfer in progress (state != IDLE)
//               o_overrun   - 1-cycle pulse, received byte dropped
//               o_underrun  - 1-cycle pulse, IDLE_BYTE loaded for transmit
// Revision    : 1.0 - initial release
// ============================================================================
module spi_peripheral
    import spi_pkg::*;
#(
    parameter logic [7:0] IDLE_BYTE   = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk,
    input  logic       i_cs_n,
    input  logic       i_mosi,
    output logic       o_miso,
    input  logic       i_tx_valid,
    input  logic [7:0] i_tx_bits,
    output logic       o_tx_ready,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    output logic [7:0] o_rx_bits,
    input  logic       i_mode_valid,
    input  logic [1:0] i_mode_bits,
    output logic       o_mode_ready,
    output logic [1:0] o_spi_mode,
    output logic       o_busy,
    output logic       o_overrun,
    output logic       o_underrun
);

    localparam logic [2:0] c_LAST_BIT = 3'(SPI_BITS - 1);

    logic       w_mosi;
    logic       w_sclk_rise;
    logic       w_sclk_fall;
    logic       w_cs_fall;
    logic       w_cs_rise;

    spi_state_t r_state_q;
    spi_state_t w_state_d;
    spi_mode_t  r_mode_q;
    logic [7:0] r_tx_shift_q;
    logic [6:0] r_rx_shift_q;
    logic [2:0] r_bit_cnt_q;
    logic       r_reload_q;     // 8th sample seen: next shift edge reloads
    logic       r_first_q;      // cpha=1: first leading edge keeps bit 7
    logic       r_rx_valid_q;
    logic [7:0] r_rx_bits_q;
    logic       r_overrun_q;
    logic       r_underrun_q;

    logic       w_lead;
    logic       w_trail;
    logic       w_sample;
    logic       w_shift;
    logic       w_load;
    logic       w_complete;
    logic       w_rx_fire;
    logic [7:0] w_rx_byte;

    spi_input_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sclk      (i_sclk),
        .i_cs_n      (i_cs_n),
        .i_mosi      (i_mosi),
        .o_mosi      (w_mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_cs_fall   (w_cs_fall),
        .o_cs_rise   (w_cs_rise)
    );

    // Leading edge is the first edge away from the idle level cpol.
    assign w_lead   = r_mode_q.cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = r_mode_q.cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample = r_mode_q.cpha ? w_trail : w_lead;
    assign w_shift  = r_mode_q.cpha ? w_lead  : w_trail;

    // Next-state and load decision. A CS rise overrides everything so a
    // tx byte is never consumed on the way back to IDLE.
    always_comb begin
        w_state_d = r_state_q;
        w_load    = 1'b0;
        unique case (r_state_q)
            IDLE: begin
                if (w_cs_fall) begin
                    w_state_d = LOAD;
                end
            end
            LOAD: begin
                w_load    = 1'b1;
                w_state_d = XFER;
            end
            XFER: begin
                w_load = w_shift & r_reload_q;
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
        if (w_cs_rise) begin
            w_state_d = IDLE;
            w_load    = 1'b0;
        end
    end

    assign w_complete = (r_state_q == XFER) && w_sample && !w_cs_rise
                        && (r_bit_cnt_q == c_LAST_BIT);
    assign w_rx_byte  = {r_rx_shift_q, w_mosi};
    assign w_rx_fire  = r_rx_valid_q & i_rx_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q    <= IDLE;
            r_mode_q     <= MODE0;
            r_tx_shift_q <= 8'hFF;
            r_rx_shift_q <= 7'd0;
            r_bit_cnt_q  <= 3'd0;
            r_reload_q   <= 1'b0;
            r_first_q    <= 1'b0;
            r_rx_valid_q <= 1'b0;
            r_rx_bits_q  <= 8'd0;
            r_overrun_q  <= 1'b0;
            r_underrun_q <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_underrun_q <= w_load & ~i_tx_valid;
            r_overrun_q  <= w_complete & r_rx_valid_q & ~w_rx_fire;

            if ((r_state_q == IDLE) && i_mode_valid) begin
                r_mode_q <= spi_mode_t'(i_mode_bits);
            end

            if (w_state_d == IDLE) begin
                r_tx_shift_q <= 8'hFF;
                r_bit_cnt_q  <= 3'd0;
                r_reload_q   <= 1'b0;
                r_first_q    <= 1'b0;
            end else if (w_load) begin
                r_tx_shift_q <= i_tx_valid ? i_tx_bits : IDLE_BYTE;
                r_reload_q   <= 1'b0;
                // Only the frame-opening load precedes a cpha=1 leading
                // edge that must not shift; a reload happens on that edge.
                r_first_q    <= r_mode_q.cpha && (r_state_q == LOAD);
                if (r_state_q == LOAD) begin
                    r_bit_cnt_q <= 3'd0;
                end
            end else if (r_state_q == XFER) begin
                if (w_sample) begin
                    r_rx_shift_q <= w_rx_byte[6:0];
                    r_bit_cnt_q  <= r_bit_cnt_q + 3'd1;   // wraps after bit 7
                    if (r_bit_cnt_q == c_LAST_BIT) begin
                        r_reload_q <= 1'b1;
                    end
                end
                if (w_shift) begin
                    if (r_first_q) begin
                        r_first_q <= 1'b0;
                    end else begin
                        r_tx_shift_q <= {r_tx_shift_q[6:0], 1'b1};
                    end
                end
            end

            // Single holding register; a same-cycle handshake frees it.
            if (w_complete && (!r_rx_valid_q || w_rx_fire)) begin
                r_rx_bits_q  <= w_rx_byte;
                r_rx_valid_q <= 1'b1;
            end else if (w_rx_fire) begin
                r_rx_valid_q <= 1'b0;
            end
        end
    end

    assign o_miso       = (r_state_q == IDLE) ? 1'b1 : r_tx_shift_q[7];
    assign o_tx_ready   = w_load & i_tx_valid;
    assign o_rx_valid   = r_rx_valid_q;
    assign o_rx_bits    = r_rx_bits_q;
    assign o_mode_ready = (r_state_q == IDLE);
    assign o_spi_mode   = r_mode_q;
    assign o_busy       = (r_state_q != IDLE);
    assign o_overrun    = r_overrun_q;
    assign o_underrun   = r_underrun_q;

endmodule : spi_peripheral
`default_nettype wire
